// File: rtl/instr_fetch.sv
// Instruction store plus run sequencer feeding simple_cpu.
// Stored words are presented in order, each held for HOLD_CYCLES cycles.
module instr_fetch #(
  parameter int INSTR_WIDTH = 20,
  parameter int ADDR_BITS   = 5,
  parameter int HOLD_CYCLES = 1,
  parameter logic [INSTR_WIDTH-1:0] NOP_WORD = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_en,
  input  logic [ADDR_BITS-1:0]   load_addr,
  input  logic [INSTR_WIDTH-1:0] load_data,
  input  logic [ADDR_BITS:0]     prog_len,
  input  logic                   start,
  input  logic                   abort,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic [ADDR_BITS-1:0]   pc,
  output logic                   busy,
  output logic                   done,
  output logic                   load_err
);

  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam int LW    = ADDR_BITS + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  logic [INSTR_WIDTH-1:0] mem [DEPTH];

  state_t                 state_q, state_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [ADDR_BITS-1:0]   pc_q, pc_d;
  logic [3:0]             hold_q, hold_d;
  logic [LW-1:0]          len_q, len_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   lerr_q, lerr_d;

  logic                   we;
  logic [ADDR_BITS-1:0]   pc_nxt;
  logic                   last_hold;
  logic                   pc_last;
  logic [INSTR_WIDTH-1:0] rd0;

  always_comb begin
    pc_nxt    = pc_q + ADDR_BITS'(1);
    last_hold = (hold_q == 4'(HOLD_CYCLES - 1));
    pc_last   = ({1'b0, pc_q} == (len_q - LW'(1)));
    // a same-cycle write to word 0 is seen by the start
    rd0 = (load_en && (load_addr == '0)) ? load_data : mem[0];
  end

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    hold_d  = hold_q;
    len_d   = len_q;
    lerr_d  = 1'b0;
    we      = 1'b0;
    unique case (state_q)
      RUN: begin
        lerr_d = load_en;
        if (abort) begin
          state_d = IDLE;
          instr_d = NOP_WORD;
          pc_d    = '0;
          hold_d  = '0;
        end else if (last_hold) begin
          hold_d = '0;
          if (pc_last) begin
            state_d = DONE;
            instr_d = NOP_WORD;
          end else begin
            pc_d    = pc_nxt;
            instr_d = mem[pc_nxt];
          end
        end else begin
          hold_d = hold_q + 4'd1;
        end
      end
      IDLE, DONE: begin
        we = load_en;
        if (abort) begin
          state_d = IDLE;
        end else if (start) begin
          pc_d   = '0;
          hold_d = '0;
          len_d  = prog_len;
          if (prog_len != '0) begin
            state_d = RUN;
            instr_d = rd0;
          end else begin
            state_d = DONE;
            instr_d = NOP_WORD;
          end
        end else if (load_en) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        instr_d = NOP_WORD;
      end
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (we) mem[load_addr] <= load_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      instr_q <= NOP_WORD;
      pc_q    <= '0;
      hold_q  <= '0;
      len_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      lerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
      len_q   <= len_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      lerr_q  <= lerr_d;
    end
  end

  assign instruction = instr_q;
  assign pc          = pc_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign load_err    = lerr_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: one DUT with hold 1, one with hold 4.
// Load, run, abort, load-in-run, boundaries and async reset.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_en1, load_en4;
  logic [4:0]  load_addr;
  logic [19:0] load_data;
  logic [5:0]  prog_len;
  logic        start1, start4, abort;

  logic [19:0] instr1, instr4;
  logic [4:0]  pc1, pc4;
  logic        busy1, busy4, done1, done4, lerr1, lerr4;

  int nvec = 0;
  int nerr = 0;

  logic [19:0] prog [3] = '{20'h1A001, 20'h2B002, 20'h3C003};

  always #5 clk = ~clk;

  instr_fetch #(.HOLD_CYCLES(1)) u_h1 (
    .clk(clk), .rst(rst), .load_en(load_en1), .load_addr(load_addr),
    .load_data(load_data), .prog_len(prog_len), .start(start1),
    .abort(abort), .instruction(instr1), .pc(pc1), .busy(busy1),
    .done(done1), .load_err(lerr1)
  );

  instr_fetch #(.HOLD_CYCLES(4)) u_h4 (
    .clk(clk), .rst(rst), .load_en(load_en4), .load_addr(load_addr),
    .load_data(load_data), .prog_len(prog_len), .start(start4),
    .abort(abort), .instruction(instr4), .pc(pc4), .busy(busy4),
    .done(done4), .load_err(lerr4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [4:0] a, input logic [19:0] d,
                           input logic both);
    load_en1  = 1'b1;
    load_en4  = both;
    load_addr = a;
    load_data = d;
    step();
    load_en1 = 1'b0;
    load_en4 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    load_en1 = 0; load_en4 = 0; load_addr = '0; load_data = '0;
    prog_len = '0; start1 = 0; start4 = 0; abort = 0;
    #12;
    nvec++; if (instr1 !== 20'h0) begin nerr++; $display("FAIL rst_instr got %h exp 00000", instr1); end
    nvec++; if (pc1 !== 5'd0) begin nerr++; $display("FAIL rst_pc got %0d exp 0", pc1); end
    nvec++; if (busy1 !== 1'b0 || done1 !== 1'b0) begin nerr++; $display("FAIL rst_flags busy %b done %b exp 0 0", busy1, done1); end
    nvec++; if (lerr1 !== 1'b0) begin nerr++; $display("FAIL rst_lerr got %b exp 0", lerr1); end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) load_word(5'(i), prog[i], 1'b1);
  endtask

  task automatic test_basic();
    prog_len = 6'd3;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      nvec++; if (instr1 !== prog[i] || pc1 !== 5'(i) || busy1 !== 1'b1)
        begin nerr++; $display("FAIL basic_%0d got %h pc %0d busy %b exp %h pc %0d busy 1", i, instr1, pc1, busy1, prog[i], i); end
      step();
    end
    nvec++; if (instr1 !== 20'h0 || done1 !== 1'b1 || pc1 !== 5'd2 || busy1 !== 1'b0)
      begin nerr++; $display("FAIL basic_end got %h done %b pc %0d exp 00000 done 1 pc 2", instr1, done1, pc1); end
  endtask

  task automatic test_hold4();
    prog_len = 6'd3;
    start4 = 1'b1;
    step();
    start4 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      nvec++; if (instr4 !== prog[i/4] || busy4 !== 1'b1 || pc4 !== 5'(i/4))
        begin nerr++; $display("FAIL hold4_c%0d got %h busy %b pc %0d exp %h busy 1 pc %0d", i, instr4, busy4, pc4, prog[i/4], i/4); end
      step();
    end
    nvec++; if (instr4 !== 20'h0 || done4 !== 1'b1 || busy4 !== 1'b0)
      begin nerr++; $display("FAIL hold4_end got %h done %b busy %b exp 00000 1 0", instr4, done4, busy4); end
  endtask

  task automatic test_abort();
    prog_len = 6'd3;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    step();
    nvec++; if (pc1 !== 5'd1) begin nerr++; $display("FAIL abort_pre pc %0d exp 1", pc1); end
    abort = 1'b1;
    step();
    abort = 1'b0;
    nvec++; if (instr1 !== 20'h0 || pc1 !== 5'd0 || busy1 !== 1'b0 || done1 !== 1'b0)
      begin nerr++; $display("FAIL abort got %h pc %0d busy %b done %b exp 00000 0 0 0", instr1, pc1, busy1, done1); end
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    nvec++; if (instr1 !== 20'h1A001 || pc1 !== 5'd0 || busy1 !== 1'b1)
      begin nerr++; $display("FAIL abort_replay got %h pc %0d exp 1a001 pc 0", instr1, pc1); end
    step(); step(); step();
    nvec++; if (done1 !== 1'b1) begin nerr++; $display("FAIL abort_replay_done got %b exp 1", done1); end
  endtask

  task automatic test_load_in_run();
    prog_len = 6'd3;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    load_en1 = 1'b1; load_addr = 5'd1; load_data = 20'hFFFFF;
    step();
    load_en1 = 1'b0;
    nvec++; if (lerr1 !== 1'b1 || instr1 !== 20'h2B002 || pc1 !== 5'd1)
      begin nerr++; $display("FAIL lrun_err lerr %b got %h pc %0d exp 1 2b002 1", lerr1, instr1, pc1); end
    step();
    nvec++; if (lerr1 !== 1'b0) begin nerr++; $display("FAIL lrun_pulse got %b exp 0", lerr1); end
    step();
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    step();
    nvec++; if (instr1 !== 20'h2B002) begin nerr++; $display("FAIL lrun_store got %h exp 2b002", instr1); end
    step(); step();
  endtask

  task automatic test_boundaries();
    prog_len = 6'd0;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    nvec++; if (done1 !== 1'b1 || busy1 !== 1'b0 || instr1 !== 20'h0)
      begin nerr++; $display("FAIL len0 done %b busy %b got %h exp 1 0 00000", done1, busy1, instr1); end
    for (int i = 3; i < 32; i++) load_word(5'(i), 20'hA0000 | 20'(i), 1'b0);
    nvec++; if (done1 !== 1'b0) begin nerr++; $display("FAIL done_load_clr got %b exp 0", done1); end
    prog_len = 6'd32;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    prog_len = 6'd2;
    for (int i = 0; i < 32; i++) begin
      logic [19:0] e;
      e = (i < 3) ? prog[i] : (20'hA0000 | 20'(i));
      nvec++; if (instr1 !== e || pc1 !== 5'(i) || busy1 !== 1'b1)
        begin nerr++; $display("FAIL len32_%0d got %h pc %0d exp %h pc %0d", i, instr1, pc1, e, i); end
      step();
    end
    nvec++; if (done1 !== 1'b1 || pc1 !== 5'd31 || instr1 !== 20'h0)
      begin nerr++; $display("FAIL len32_end done %b pc %0d got %h exp 1 31 00000", done1, pc1, instr1); end
    abort = 1'b1;
    step();
    nvec++; if (done1 !== 1'b0) begin nerr++; $display("FAIL abort_done got %b exp 0", done1); end
    prog_len = 6'd3;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    abort = 1'b0;
    nvec++; if (busy1 !== 1'b0 || done1 !== 1'b0 || instr1 !== 20'h0)
      begin nerr++; $display("FAIL start_abort busy %b done %b got %h exp 0 0 00000", busy1, done1, instr1); end
  endtask

  task automatic test_write_first();
    prog_len = 6'd1;
    load_en1 = 1'b1; load_addr = 5'd0; load_data = 20'h12345;
    start1 = 1'b1;
    step();
    load_en1 = 1'b0;
    start1 = 1'b0;
    nvec++; if (instr1 !== 20'h12345 || busy1 !== 1'b1)
      begin nerr++; $display("FAIL wfirst got %h busy %b exp 12345 1", instr1, busy1); end
    step();
    nvec++; if (done1 !== 1'b1 || instr1 !== 20'h0)
      begin nerr++; $display("FAIL wfirst_end done %b got %h exp 1 00000", done1, instr1); end
    load_word(5'd0, 20'h1A001, 1'b0);
  endtask

  task automatic test_async_reset();
    prog_len = 6'd3;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    step();
    #2;
    rst = 1'b0;
    #1;
    nvec++; if (instr1 !== 20'h0 || busy1 !== 1'b0 || pc1 !== 5'd0)
      begin nerr++; $display("FAIL arst got %h busy %b pc %0d exp 00000 0 0", instr1, busy1, pc1); end
    @(negedge clk);
    rst = 1'b1;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      nvec++; if (instr1 !== prog[i] || pc1 !== 5'(i))
        begin nerr++; $display("FAIL arst_replay_%0d got %h pc %0d exp %h", i, instr1, pc1, prog[i]); end
      step();
    end
    nvec++; if (done1 !== 1'b1) begin nerr++; $display("FAIL arst_done got %b exp 1", done1); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold4();
    test_abort();
    test_load_in_run();
    test_boundaries();
    test_write_first();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
